// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// reset vector and sequential address increment.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    STALL    = 2'd2,
    REDIRECT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR      = 32'd4;
  localparam logic [31:0] ADDR_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory read bus between the fetch controller (master) and
// the instruction memory (slave).
interface fetch_controller_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/fetch_wait_timer.sv
// Counts consecutive un-acknowledged fetch cycles and raises a sticky
// timeout once MAX_WAIT of them have elapsed.
module fetch_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (active_i && !ready_i) begin
      // Saturate so the count never wraps back below the limit.
      cnt_d = (cnt_q != LIMIT) ? cnt_q + CW'(1) : cnt_q;
      if (cnt_d == LIMIT) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_o = err_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: sequential fetch, downstream stall,
// branch redirect with IF/ID flush, and memory timeout reporting.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      freeze,
  input  logic                      Br_taken,
  input  logic [31:0]               Br_Addr,
  fetch_controller_if.master        mem,
  output logic [31:0]               PC,
  output logic [31:0]               Instruction,
  output logic                      inst_valid,
  output logic                      flush,
  output logic                      fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         capture;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    capture      = 1'b0;

    if (Br_taken) begin
      state_d      = REDIRECT;
      fetch_addr_d = Br_Addr & ADDR_MASK;
      valid_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE:     state_d = FETCH;
        FETCH: begin
          // A returned word is only taken if the held one is free to move on;
          // otherwise it is dropped and the same address is fetched again.
          capture = mem.mem_ready && !(valid_q && freeze);
          if (capture) begin
            instr_d      = mem.mem_rdata;
            pc_d         = fetch_addr_q + PC_INCR;
            fetch_addr_d = fetch_addr_q + PC_INCR;
            valid_d      = 1'b1;
            state_d      = freeze ? STALL : FETCH;
          end else if (valid_q) begin
            if (freeze) begin
              state_d = STALL;
            end else begin
              valid_d = 1'b0;
            end
          end
        end
        STALL:    if (!freeze) state_d = FETCH;
        REDIRECT: state_d = FETCH;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_VECTOR;
      pc_q         <= '0;
      instr_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
    end
  end

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .active_i  (state_q == FETCH),
    .ready_i   (mem.mem_ready),
    .timeout_o (fetch_err)
  );

  assign mem.mem_req  = (state_q == FETCH);
  assign mem.mem_addr = fetch_addr_q;
  assign PC           = pc_q;
  assign Instruction  = instr_q;
  assign inst_valid   = valid_q;
  assign flush        = (state_q == REDIRECT);

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter MAX_WAIT, default 15, SHALL set the number of FETCH cycles without mem_ready before fetch_err sets.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 freeze  input  1  downstream stall; held instruction not consumed this cycle.
REQ-005 Br_taken  input  1  redirect request, sampled every cycle.
REQ-006 Br_Addr  input  32  redirect target; bits [1:0] SHALL be ignored and treated as 00.
REQ-007 mem_ready  input  1  instruction memory read complete this cycle; meaningful only while mem_req=1.
REQ-008 mem_rdata  input  32  instruction word, valid with mem_ready.
REQ-009 mem_req  output  1  read request; may be withdrawn before mem_ready without side effect.
REQ-010 mem_addr  output  32  word-aligned fetch address.
REQ-011 PC  output  32  address of the held instruction plus 4.
REQ-012 Instruction  output  32  held instruction word.
REQ-013 inst_valid  output  1  Instruction/PC hold a live instruction.
REQ-014 flush  output  1  one-cycle pulse telling the IF/ID register to discard its contents.
REQ-015 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-016 States SHALL be IDLE, FETCH, STALL, REDIRECT.
REQ-017 mem_req SHALL equal (state==FETCH); mem_addr SHALL equal the fetch_addr register in every state.
REQ-018 IDLE SHALL go to FETCH on the next cycle unconditionally, unless Br_taken is asserted.
REQ-019 Br_taken=1 in any state SHALL, next cycle, set state=REDIRECT, fetch_addr={Br_Addr[31:2],2'b00}, inst_valid=0, flush=1; same-cycle mem_ready and freeze SHALL be ignored.
REQ-020 REDIRECT SHALL last one cycle with mem_req=0, then go to FETCH; Br_taken in REDIRECT SHALL restart REDIRECT with the new target.
REQ-021 Capture: in FETCH with mem_ready=1, Br_taken=0, and not (inst_valid=1 and freeze=1), next cycle SHALL set Instruction=mem_rdata, PC=fetch_addr+4, inst_valid=1, and fetch_addr=fetch_addr+4.
REQ-022 Capture with freeze=1 SHALL go to STALL; otherwise stay in FETCH.
REQ-023 FETCH with inst_valid=1, freeze=1 and no capture SHALL go to STALL; any same-cycle mem_ready SHALL be discarded and the same address refetched later.
REQ-024 FETCH with inst_valid=1, freeze=0 and no capture SHALL clear inst_valid (bubble).
REQ-025 STALL SHALL hold PC, Instruction, inst_valid and fetch_addr, and SHALL go to FETCH when freeze=0.
REQ-026 While inst_valid=1 and freeze=1, PC and Instruction SHALL NOT change except on Br_taken.
REQ-027 fetch_addr+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-028 Wait counter SHALL increment each FETCH cycle without mem_ready and clear on mem_ready or on leaving FETCH; reaching MAX_WAIT SHALL set fetch_err until reset, and fetching SHALL continue.
REQ-029 flush SHALL be high only in REDIRECT cycles.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, fetch_addr=0, PC=0, Instruction=0, inst_valid=0, flush=0, fetch_err=0, wait counter=0, hence mem_req=0.
REQ-031 Reset during an outstanding fetch SHALL abandon that fetch; the first request after release SHALL use mem_addr=0.

Structure
REQ-032 A shared package SHALL hold the state encoding, RESET_VECTOR (32'h0) and PC_INCR (32'd4).
REQ-033 The wait counter and timeout compare SHALL be one sub-module, fetch_wait_timer; all other logic stays in fetch_controller.

Verification
REQ-034 Release reset, mem_ready=1 every cycle, rdata=addr -> IDLE, then mem_addr 0,4,8; Instruction=0,4,8; PC=4,8,12; inst_valid=1 from the 3rd cycle on.
REQ-035 Set freeze=1 for 3 cycles while holding Instruction at 0x8 -> PC=0xC and Instruction held, mem_req=0; after release, the next fetch is at 0xC.
REQ-036 Assert Br_taken with Br_Addr=0x103 during a pending FETCH -> next cycle flush=1, inst_valid=0, mem_addr=0x100; the following cycle mem_req=1 at 0x100.
REQ-037 Assert Br_taken and mem_ready together -> rdata discarded, PC unchanged, redirect taken.
REQ-038 Hold mem_ready=0 for 15 FETCH cycles with MAX_WAIT=15 -> fetch_err=1 stays set after a later mem_ready; rst clears it.
REQ-039 Redirect to 0xFFFFFFFC with ready always high -> PC=0x00000000 and next mem_addr=0x00000000.
